// File: rtl/mem_port_arbiter.sv
// Unified memory port arbiter: shares one memory port between fetch and data.
// Data wins contention unless fetch has been starved; responses are tag-routed.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]         r_starve_cnt;
  logic [MEM_LAT-1:0] r_tag_v;
  logic [MEM_LAT-1:0] r_tag_if;
  logic [MEM_LAT-1:0] r_tag_st;

  logic w_starved;
  logic w_if_win;
  logic w_d_win;
  logic w_any;
  logic w_ret_v;
  logic w_ret_if;
  logic w_ret_st;

  // Fetch is forced through once it has lost STARVE_MAX times in a row.
  assign w_starved = (r_starve_cnt == STARVE_LIM);
  assign w_if_win  = ~rst & if_req & (~d_req | w_starved);
  assign w_d_win   = ~rst & d_req & ~w_if_win;
  assign w_any     = w_if_win | w_d_win;

  assign if_gnt = w_if_win;
  assign d_gnt  = w_d_win;

  // Drive the memory port from whichever requester won; zero when idle.
  always_comb begin
    mem_en    = w_any;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (w_if_win) begin
      mem_addr = if_addr;
      mem_be   = {BE_W{1'b1}};
    end else if (w_d_win) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_be;
    end
  end

  // Count consecutive fetch denials; any grant or dropped request resets it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (~if_req | w_if_win) begin
      r_starve_cnt <= '0;
    end else if (!w_starved) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // Shift grant tags along so each response finds its owner MEM_LAT later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_v  <= '0;
      r_tag_if <= '0;
      r_tag_st <= '0;
    end else begin
      r_tag_v[0]  <= w_any;
      r_tag_if[0] <= w_if_win;
      r_tag_st[0] <= w_d_win & d_we;
      for (int i = 1; i < MEM_LAT; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_if[i] <= r_tag_if[i-1];
        r_tag_st[i] <= r_tag_st[i-1];
      end
    end
  end

  assign w_ret_v  = r_tag_v[MEM_LAT-1];
  assign w_ret_if = r_tag_if[MEM_LAT-1];
  assign w_ret_st = r_tag_st[MEM_LAT-1];

  // Route returning data to its owner; stores ack with zero data.
  always_comb begin
    if_rvalid = w_ret_v & w_ret_if;
    d_rvalid  = w_ret_v & ~w_ret_if;
    if_rdata  = '0;
    d_rdata   = '0;
    if (if_rvalid) begin
      if_rdata = mem_rdata;
    end
    if (d_rvalid & ~w_ret_st) begin
      d_rdata = mem_rdata;
    end
  end

endmodule
